// File: rtl/unified_mem_arbiter_pkg.sv
// Package for unified_mem_arbiter.
// Contents: the FSM state encoding, the owner constants, the width of the
// starvation counter, and a helper that decodes which requester owns a
// busy state.
package unified_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        BUSY_IF      = 2'd1,
        BUSY_D       = 2'd2,
        BUSY_IF_DROP = 2'd3
    } arbState_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    localparam int unsigned STARVE_CTR_W = 4;

    // A dropped fetch still belongs to the fetch side; only BUSY_D is data.
    function automatic owner_e stateOwner(arbState_e s);
        return (s == BUSY_D) ? OWNER_D : OWNER_IF;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for unified_mem_arbiter.
// Pipeline side: if_* (fetch), d_* (load/store), stall_if/stall_mem.
// Memory side:   m_req/m_we/m_addr/m_wdata out, m_done/m_rdata in.
// Modport master is the arbiter's view. Modport slave is the view of the
// pipeline and memory that surround it.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              stall_if;
    logic              stall_mem;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_done;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata,
               m_done, m_rdata,
        output if_done, if_rdata, d_done, d_rdata, stall_if, stall_mem,
               m_req, m_we, m_addr, m_wdata
    );

    modport slave (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata,
               m_done, m_rdata,
        input  if_done, if_rdata, d_done, d_rdata, stall_if, stall_mem,
               m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter_starve_ctr.sv
// arb_starve_ctr: a 4-bit saturating counter of data grants made while a
// fetch was waiting.
// Ports: clk, rst (sync, active-high), inc, clr (clr wins), hit (count has
//        reached LIMIT).
// This counter is used only when UNIFIED_MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr
    import unified_mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    logic [STARVE_CTR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

    // Using >= keeps the fetch forced if a flushed fetch let one more data
    // grant through after the limit was reached.
    assign hit = (count >= STARVE_CTR_W'(LIMIT));
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch (IF) and
// the memory stage (MEM). One transaction is outstanding at a time.
// Ports: clk, rst (sync, active-high), bus (unified_mem_arbiter_if.master):
//   if_req/if_addr/if_flush -> if_done/if_rdata, stall_if
//   d_req/d_we/d_addr/d_wdata -> d_done/d_rdata, stall_mem
//   m_req/m_we/m_addr/m_wdata (registered) <- m_done/m_rdata
// Optional: UNIFIED_MEM_ARB_STARVE_GUARD_EN. When it is defined, fetch is
// forced after STARVE_LIMIT consecutive data grants made while fetch waited.
// Without it, data always has priority.
module unified_mem_arbiter
    import unified_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.master bus
);
    arbState_e state;
    logic      ifWant, forceIf, grantD, grantIf, doneNow;

    // A fetch raised in the same cycle as a flush is already stale.
    assign ifWant = bus.if_req & ~bus.if_flush;

`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
    logic starveHit, ctrInc, ctrClr;

    assign ctrInc = (state == IDLE) & grantD & bus.if_req;
    assign ctrClr = (state == IDLE) & (grantIf | ~bus.if_req);

    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) uStarve (
        .clk (clk),
        .rst (rst),
        .inc (ctrInc),
        .clr (ctrClr),
        .hit (starveHit)
    );

    assign forceIf = starveHit & ifWant;
`else
    assign forceIf = 1'b0;
`endif

    // The older instruction in MEM wins unless fetch has starved.
    assign grantD  = bus.d_req & ~forceIf;
    assign grantIf = ifWant & ~grantD;

    // A reset in the completion cycle abandons the access, so no pulse is sent.
    assign doneNow = (state != IDLE) & bus.m_done & ~rst;

    assign bus.d_done   = doneNow & (stateOwner(state) == OWNER_D);
    assign bus.if_done  = doneNow & (state == BUSY_IF) & ~bus.if_flush;
    assign bus.d_rdata  = bus.m_rdata;
    assign bus.if_rdata = bus.m_rdata;

    assign bus.stall_if  = bus.if_req & ~bus.if_done & ~bus.if_flush;
    assign bus.stall_mem = bus.d_req & ~bus.d_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grantD) begin
                        state       <= BUSY_D;
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.d_we;
                        bus.m_addr  <= bus.d_addr;
                        bus.m_wdata <= bus.d_wdata;
                    end else if (grantIf) begin
                        state       <= BUSY_IF;
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= 1'b0;
                        bus.m_addr  <= bus.if_addr;
                        bus.m_wdata <= '0;
                    end
                end
                BUSY_IF: begin
                    if (bus.m_done) begin
                        state     <= IDLE;
                        bus.m_req <= 1'b0;
                    end else if (bus.if_flush) begin
                        // The memory access cannot be aborted. It runs to
                        // completion with its result discarded.
                        state <= BUSY_IF_DROP;
                    end
                end
                BUSY_D, BUSY_IF_DROP: begin
                    if (bus.m_done) begin
                        state     <= IDLE;
                        bus.m_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed plus randomized bench for unified_mem_arbiter.
// Includes a behavioural memory with configurable or random latency, and a
// transaction-level reference of the memory contents.
module tb_unified_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory contents. Unwritten words read as a per-address pattern.
    logic [31:0] memArr [logic [31:0]];
    logic [31:0] refArr [logic [31:0]];
    int memLat       = 0;
    bit randLat      = 1'b0;
    bit spuriousDone = 1'b0;
    bit memBusy      = 1'b0;
    int waitCnt      = 0;

    function automatic logic [31:0] dflt(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function logic [31:0] memRead(logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : dflt(a);
    endfunction

    function logic [31:0] refRead(logic [31:0] a);
        return refArr.exists(a) ? refArr[a] : dflt(a);
    endfunction

    // The memory answers L cycles after the first m_req cycle (L=0: same cycle).
    always @(posedge clk) begin
        #1;
        bus.m_done = 1'b0;
        if (bus.m_req) begin
            if (!memBusy) begin
                memBusy = 1'b1;
                waitCnt = randLat ? int'($urandom_range(0, 3)) : memLat;
            end
            if (waitCnt == 0) begin
                bus.m_done  = 1'b1;
                bus.m_rdata = memRead(bus.m_addr);
                if (bus.m_we) memArr[bus.m_addr] = bus.m_wdata;
                memBusy = 1'b0;
            end else begin
                waitCnt--;
            end
        end else begin
            memBusy = 1'b0;
        end
        if (spuriousDone) begin
            bus.m_done  = 1'b1;
            bus.m_rdata = 32'hBAD0_BAD0;
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the sample point of the next cycle.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    bit          ifPend, dPend, dWe, gotIf, expIf, issue;
    logic [31:0] ifA, dA, dD;
    int          ifAge, dAge, nGrant;

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        memArr[32'h10] = 32'h0050_0093;

        // Reset state
        repeat (3) cyc();
        chk("rst_m_req", bus.m_req, 0);
        chk("rst_m_we", bus.m_we, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_if_done", bus.if_done, 0);
        chk("rst_d_done", bus.d_done, 0);
        rst = 0;
        cyc();

        // Fetch only, L=0
        memLat = 0; bus.if_req = 1; bus.if_addr = 32'h10;
        #1 chk("t1_stall_if_wait", bus.stall_if, 1);
        cyc();
        chk("t1_m_req", bus.m_req, 1);
        chk("t1_m_addr", bus.m_addr, 32'h10);
        chk("t1_m_we", bus.m_we, 0);
        chk("t1_if_done", bus.if_done, 1);
        chk("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
        chk("t1_stall_if_done", bus.stall_if, 0);
        bus.if_req = 0;
        cyc();
        chk("t1_m_req_clr", bus.m_req, 0);
        chk("t1_if_done_clr", bus.if_done, 0);

        // Both request: the store goes first, L=2, then the fetch
        memLat = 2;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEAD_BEEF;
        bus.if_req = 1; bus.if_addr = 32'h40;
        cyc(); // t+1
        chk("t2_m_we", bus.m_we, 1);
        chk("t2_m_addr", bus.m_addr, 32'h20);
        chk("t2_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        chk("t2_stall_mem", bus.stall_mem, 1);
        cyc(); // t+2
        chk("t2_d_done_early", bus.d_done, 0);
        cyc(); // t+3
        chk("t2_d_done", bus.d_done, 1);
        chk("t2_stall_if_during_d", bus.stall_if, 1);
        chk("t2_stall_mem_done", bus.stall_mem, 0);
        bus.d_req = 0;
        cyc(); // t+4: the fetch is granted in this IDLE cycle
        chk("t2_idle_m_req", bus.m_req, 0);
        chk("t2_stall_if_t4", bus.stall_if, 1);
        cyc(); // t+5
        chk("t2_f_m_req", bus.m_req, 1);
        chk("t2_f_m_addr", bus.m_addr, 32'h40);
        chk("t2_f_m_we", bus.m_we, 0);
        chk("t2_stall_if_t5", bus.stall_if, 1);
        cyc(); // t+6
        chk("t2_stall_if_t6", bus.stall_if, 1);
        cyc(); // t+7
        chk("t2_if_done", bus.if_done, 1);
        chk("t2_if_rdata", bus.if_rdata, dflt(32'h40));
        bus.if_req = 0;
        cyc();
        // A load reads back the stored word
        memLat = 1; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h20;
        cyc(); cyc();
        chk("t2_load_done", bus.d_done, 1);
        chk("t2_load_data", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 0;
        cyc();

        // Flush during BUSY_IF, L=3
        memLat = 3; bus.if_req = 1; bus.if_addr = 32'h50;
        cyc(); // t+1
        chk("t3_m_req", bus.m_req, 1);
        bus.if_flush = 1; bus.if_req = 0;
        #1 chk("t3_stall_if_flush", bus.stall_if, 0);
        cyc(); // t+2
        chk("t3_if_done_t2", bus.if_done, 0);
        bus.if_flush = 0;
        cyc(); // t+3
        chk("t3_if_done_t3", bus.if_done, 0);
        memLat = 0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
        cyc(); // t+4: memory completes the dropped fetch
        chk("t3_if_done_t4", bus.if_done, 0);
        chk("t3_d_done_t4", bus.d_done, 0);
        chk("t3_m_req_t4", bus.m_req, 1);
        cyc(); // t+5: IDLE
        chk("t3_m_req_t5", bus.m_req, 0);
        chk("t3_stall_mem_t5", bus.stall_mem, 1);
        cyc(); // t+6
        chk("t3_m_addr_t6", bus.m_addr, 32'h10);
        chk("t3_d_done_t6", bus.d_done, 1);
        chk("t3_d_rdata_t6", bus.d_rdata, 32'h0050_0093);
        bus.d_req = 0;
        cyc();

        // Flush in the same IDLE cycle as the fetch request
        bus.if_req = 1; bus.if_flush = 1; bus.if_addr = 32'h60;
        #1 chk("t3b_stall_if", bus.stall_if, 0);
        cyc();
        chk("t3b_no_grant", bus.m_req, 0);
        bus.if_req = 0; bus.if_flush = 0;
        cyc();

        // Priority with both requests held, L=0
        memLat = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
        bus.if_req = 1; bus.if_addr = 32'h200;
        nGrant = 0;
        for (int c = 0; c < 40 && nGrant < 6; c++) begin
            cyc();
            if (bus.m_req) begin
                gotIf = (bus.m_addr == 32'h200);
`ifdef UNIFIED_MEM_ARB_STARVE_GUARD_EN
                expIf = ((nGrant % (LIMIT + 1)) == LIMIT);
`else
                expIf = 1'b0;
`endif
                chk($sformatf("t4_grant%0d_is_fetch", nGrant), gotIf, expIf);
                nGrant++;
            end
        end
        chk("t4_grant_count", nGrant, 6);
        bus.d_req = 0; bus.if_req = 0;
        cyc(); cyc();

        // Reset while in BUSY_D, L=5
        memLat = 5;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h30; bus.d_wdata = 32'h1234_5678;
        cyc(); // t+1
        chk("t5_m_req", bus.m_req, 1);
        cyc(); // t+2
        rst = 1;
        #1 chk("t5_d_done_rst", bus.d_done, 0);
        cyc(); // t+3
        chk("t5_m_req_after_rst", bus.m_req, 0);
        chk("t5_d_done_after_rst", bus.d_done, 0);
        rst = 0; memLat = 0;
        cyc(); // t+4: the held request gets a fresh grant from IDLE
        chk("t5_regrant", bus.m_req, 1);
        chk("t5_d_done_new", bus.d_done, 1);
        bus.d_req = 0;
        cyc();

        // m_done pulsed in IDLE with no requests
        spuriousDone = 1;
        cyc();
        chk("t6_if_done", bus.if_done, 0);
        chk("t6_d_done", bus.d_done, 0);
        chk("t6_m_req", bus.m_req, 0);
        spuriousDone = 0;
        cyc();
        chk("t6_m_req_after", bus.m_req, 0);

        // Random traffic checked against the reference memory contents
        foreach (memArr[a]) refArr[a] = memArr[a];
        randLat = 1;
        ifPend = 0; dPend = 0; ifAge = 0; dAge = 0; dWe = 0;
        ifA = 0; dA = 0; dD = 0;
        for (int c = 0; c < 3000; c++) begin
            issue = (c < 2800);
            cyc();
            chk("r_one_done", bus.if_done & bus.d_done, 0);
            if (bus.d_done) begin
                chk("r_d_done_pending", dPend, 1);
                if (dWe) refArr[dA] = dD;
                else     chk("r_d_rdata", bus.d_rdata, refRead(dA));
                dPend = 0;
            end
            // A completion in the flush cycle itself is not compared: the
            // fetch it belongs to has already been cancelled by the pipeline.
            if (bus.if_done && !bus.if_flush) begin
                chk("r_if_done_pending", ifPend, 1);
                chk("r_if_rdata", bus.if_rdata, refRead(ifA));
                ifPend = 0;
            end
            if (dPend) begin
                dAge++;
                chk("r_d_age", dAge <= 120, 1);
                if (dAge > 120) dPend = 0;
            end
            if (ifPend) begin
                ifAge++;
                chk("r_if_age", ifAge <= 120, 1);
                if (ifAge > 120) ifPend = 0;
            end

            bus.if_flush = 0;
            if (ifPend && $urandom_range(0, 15) == 0) begin
                bus.if_flush = 1;
                ifPend = 0;
            end else if (issue && !ifPend && $urandom_range(0, 2) == 0) begin
                ifPend = 1; ifAge = 0;
                ifA = 32'($urandom_range(0, 15)) << 2;
            end
            if (issue && !dPend && $urandom_range(0, 3) == 0) begin
                dPend = 1; dAge = 0;
                dWe = 1'($urandom_range(0, 1));
                dA = 32'($urandom_range(0, 15)) << 2;
                dD = $urandom;
            end
            bus.if_req = ifPend; bus.if_addr = ifA;
            bus.d_req = dPend; bus.d_we = dWe; bus.d_addr = dA; bus.d_wdata = dD;
        end
        chk("r_drained_d", dPend, 0);
        chk("r_drained_if", ifPend, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
